delaygen_mc: RTL and testbench

Multi-channel programmable delay generator, the parametrised successor to the single fixed-count delay block. Each of NUM_CH independent channels is started by a one-cycle request, counts a per-channel programmable delay latched at start, then signals expiry with a one-cycle pulse and a sticky level. Channels run one-shot or periodic and can be retriggered or stopped. Used by sequencing logic that needs several concurrent, software-programmable timeouts or ticks from one clock.

---
 rtl/delaygen_pkg.sv | 8 +
 rtl/delaygen_ch.sv | 71 +++++++
 rtl/delaygen_mc.sv | 38 +++
 tb/tb_delaygen_mc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/delaygen_pkg.sv
// Shared types and defaults for the multi-channel delay generator.
package delaygen_pkg;

    typedef enum logic {StIdle, StRun} state_e;

    localparam int unsigned DefaultCntW = 16;

endpackage

// File: rtl/delaygen_ch.sv
// One delay channel: latches a delay on start, counts it down, then pulses expire
// and sets a sticky out level; periodic mode reloads and keeps running.
module delaygen_ch
    import delaygen_pkg::*;
#(
    parameter int unsigned CNT_W     = DefaultCntW,
    parameter bit          RETRIGGER = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             periodic_i,
    input  logic [CNT_W-1:0] delay_i,
    output logic             busy_o,
    output logic             expire_o,
    output logic             out_o
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   dly_q;
    logic               mode_q;
    logic               expire_q;
    logic               out_q;

    logic load;
    assign load = start_i && ((state_q == StIdle) || RETRIGGER);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            dly_q    <= '0;
            mode_q   <= 1'b0;
            expire_q <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            expire_q <= 1'b0;
            // Priority: stop, then (re)load, then counting/expiry.
            if (stop_i) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                out_q   <= 1'b0;
            end else if (load) begin
                state_q <= StRun;
                cnt_q   <= delay_i;
                dly_q   <= delay_i;
                mode_q  <= periodic_i;
                out_q   <= 1'b0;
            end else if (state_q == StRun) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    expire_q <= 1'b1;
                    out_q    <= 1'b1;
                    if (mode_q) begin
                        cnt_q <= dly_q;
                    end else begin
                        state_q <= StIdle;
                    end
                end
            end
        end
    end

    assign busy_o   = (state_q == StRun);
    assign expire_o = expire_q;
    assign out_o    = out_q;

endmodule

// File: rtl/delaygen_mc.sv
// Multi-channel programmable delay generator: NUM_CH independent delaygen_ch
// instances, each fed its own slice of the packed delay bus.
module delaygen_mc
    import delaygen_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = DefaultCntW,
    parameter bit          RETRIGGER = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       periodic,
    input  logic [NUM_CH*CNT_W-1:0] delay,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       expire,
    output logic [NUM_CH-1:0]       out
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        delaygen_ch #(
            .CNT_W     (CNT_W),
            .RETRIGGER (RETRIGGER)
        ) u_ch (
            .clk_i      (clk),
            .rst_i      (rst),
            .start_i    (start[i]),
            .stop_i     (stop[i]),
            .periodic_i (periodic[i]),
            .delay_i    (delay[i*CNT_W +: CNT_W]),
            .busy_o     (busy[i]),
            .expire_o   (expire[i]),
            .out_o      (out[i])
        );
    end

endmodule

// File: tb/tb_delaygen_mc.sv
// Bench for delaygen_mc: one retriggerable and one non-retriggerable instance, checked
// against an absolute-time expiry model, a directed vector table and corner sequences.
module tb_delaygen_mc;

    localparam int NCH = 4;
    localparam int CW  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   start = '0, stop = '0, periodic = '0;
    logic [NCH*CW-1:0] delay = '0;
    logic [NCH-1:0]   busy_r, expire_r, out_r;
    logic [NCH-1:0]   busy_n, expire_n, out_n;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    delaygen_mc #(.NUM_CH(NCH), .CNT_W(CW), .RETRIGGER(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
        .delay(delay), .busy(busy_r), .expire(expire_r), .out(out_r)
    );

    delaygen_mc #(.NUM_CH(NCH), .CNT_W(CW), .RETRIGGER(1'b0)) dut_nr (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
        .delay(delay), .busy(busy_n), .expire(expire_n), .out(out_n)
    );

    always #5 clk = ~clk;

    // Model: a running channel fires at an absolute cycle; periodic reschedules by D+1.
    // Index 0 models RETRIGGER=1, index 1 models RETRIGGER=0.
    bit [NCH-1:0] m_run [2];
    bit [NCH-1:0] m_mode [2];
    bit [NCH-1:0] m_out [2];
    bit [NCH-1:0] m_exp [2];
    int           m_fire [2][NCH];
    int           m_per [2][NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int v = 0; v < 2; v++) begin
            for (int c = 0; c < NCH; c++) begin
                m_exp[v][c] = 1'b0;
                if (rst) begin
                    m_run[v][c] = 1'b0;
                    m_out[v][c] = 1'b0;
                end else if (stop[c]) begin
                    m_run[v][c] = 1'b0;
                    m_out[v][c] = 1'b0;
                end else if (start[c] && (!m_run[v][c] || v == 0)) begin
                    m_run[v][c]  = 1'b1;
                    m_per[v][c]  = int'(delay[c*CW +: CW]) + 1;
                    m_fire[v][c] = cyc + m_per[v][c];
                    m_mode[v][c] = periodic[c];
                    m_out[v][c]  = 1'b0;
                end else if (m_run[v][c] && cyc == m_fire[v][c]) begin
                    m_exp[v][c] = 1'b1;
                    m_out[v][c] = 1'b1;
                    if (m_mode[v][c]) m_fire[v][c] = m_fire[v][c] + m_per[v][c];
                    else m_run[v][c] = 1'b0;
                end
            end
        end
        #1;
        check("busy_rt", 32'(busy_r), 32'(m_run[0]));
        check("expire_rt", 32'(expire_r), 32'(m_exp[0]));
        check("out_rt", 32'(out_r), 32'(m_out[0]));
        check("busy_nrt", 32'(busy_n), 32'(m_run[1]));
        check("expire_nrt", 32'(expire_n), 32'(m_exp[1]));
        check("out_nrt", 32'(out_n), 32'(m_out[1]));
    endtask

    task automatic drive(input logic [NCH-1:0] st, input logic [NCH-1:0] sp,
                         input logic [NCH-1:0] per, input logic [NCH*CW-1:0] d);
        start = st; stop = sp; periodic = per; delay = d;
        tick();
        start = '0; stop = '0;
    endtask

    typedef struct {
        logic          st;
        logic          sp;
        logic [CW-1:0] d;
        logic          busy;
        logic          exp;
        logic          out;
    } vec_t;

    vec_t tbl [14];

    int t_r, t_n, cnt_r, cnt_n;
    int first [NCH];
    logic busy_all;

    initial begin
        // Channel 0, one-shot: D=5 starting at cycle 10, stop, D=0, start+stop.
        tbl[0]  = '{1'b1, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("reset_busy", 32'(busy_r | busy_n), 32'd0);
        check("reset_out", 32'(out_r | out_n), 32'd0);
        while (cyc < 9) tick();

        for (int i = 0; i < 14; i++) begin
            drive({3'b0, tbl[i].st}, {3'b0, tbl[i].sp}, '0, {24'd0, tbl[i].d});
            check($sformatf("tbl%0d_busy", i), 32'(busy_r[0]), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_expire", i), 32'(expire_r[0]), 32'(tbl[i].exp));
            check($sformatf("tbl%0d_out", i), 32'(out_r[0]), 32'(tbl[i].out));
        end

        // Channel 1 periodic D=2: pulse every 3 cycles, busy continuous, then stop.
        drive(4'b0010, '0, 4'b0010, {8'd0, 8'd0, 8'd2, 8'd0});
        cnt_r = 0; busy_all = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            cnt_r += int'(expire_r[1]);
            busy_all &= busy_r[1];
        end
        check("per_count", 32'(cnt_r), 32'd3);
        check("per_busy", 32'(busy_all), 32'd1);
        check("per_out", 32'(out_r[1]), 32'd1);
        drive('0, 4'b0010, '0, '0);
        check("per_stop_busy", 32'(busy_r[1]), 32'd0);
        check("per_stop_out", 32'(out_r[1]), 32'd0);
        cnt_r = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            cnt_r += int'(expire_r[1]);
        end
        check("per_stop_quiet", 32'(cnt_r), 32'd0);

        // Channel 2 full-scale delay: expire 2^CW cycles after start, no wrap.
        drive(4'b0100, '0, '0, {8'd0, 8'hff, 8'd0, 8'd0});
        t_r = -1;
        for (int i = 1; i <= 300 && t_r < 0; i++) begin
            tick();
            if (expire_r[2]) t_r = i;
        end
        check("max_delay_latency", 32'(t_r), 32'd256);

        // Channel 3: D=10, then start D=3 four cycles later.
        drive(4'b1000, '0, '0, {8'd10, 24'd0});
        repeat (3) tick();
        drive(4'b1000, '0, '0, {8'd3, 24'd0});
        t_r = -1; t_n = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (expire_r[3] && t_r < 0) t_r = i;
            if (expire_n[3] && t_n < 0) t_n = i;
        end
        check("retrig_latency", 32'(t_r), 32'd4);
        check("noretrig_latency", 32'(t_n), 32'd7);

        // Start landing on the expiry cycle: retrigger suppresses expire, else it fires.
        drive(4'b1000, '0, '0, {8'd2, 24'd0});
        repeat (2) tick();
        drive(4'b1000, '0, '0, {8'd2, 24'd0});
        check("coinc_rt_expire", 32'(expire_r[3]), 32'd0);
        check("coinc_nrt_expire", 32'(expire_n[3]), 32'd1);
        t_r = -1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (expire_r[3] && t_r < 0) t_r = i;
        end
        check("coinc_rt_latency", 32'(t_r), 32'd3);

        // Back-to-back one-shots on channel 0.
        drive(4'b0001, '0, '0, {24'd0, 8'd1});
        repeat (2) tick();
        drive(4'b0001, '0, '0, {24'd0, 8'd1});
        check("b2b_busy", 32'(busy_r[0]), 32'd1);
        repeat (3) tick();

        // All channels together with D=1,4,7,0.
        for (int c = 0; c < NCH; c++) first[c] = -1;
        drive(4'hf, '0, '0, {8'd0, 8'd7, 8'd4, 8'd1});
        for (int i = 1; i <= 10; i++) begin
            tick();
            for (int c = 0; c < NCH; c++) if (expire_r[c] && first[c] < 0) first[c] = i;
        end
        check("all_ch0", 32'(first[0]), 32'd2);
        check("all_ch1", 32'(first[1]), 32'd5);
        check("all_ch2", 32'(first[2]), 32'd8);
        check("all_ch3", 32'(first[3]), 32'd1);

        // Reset mid-count aborts silently.
        drive(4'hf, '0, 4'b0101, {8'd20, 8'd20, 8'd20, 8'd20});
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy_r | busy_n), 32'd0);
        check("rst_mid_out", 32'(out_r | out_n), 32'd0);
        check("rst_mid_expire", 32'(expire_r | expire_n), 32'd0);
        cnt_r = 0; cnt_n = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            cnt_r += $countones(expire_r);
            cnt_n += $countones(expire_n);
        end
        check("rst_mid_quiet_rt", 32'(cnt_r), 32'd0);
        check("rst_mid_quiet_nrt", 32'(cnt_n), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [NCH-1:0]    st, sp, per;
            logic [NCH*CW-1:0] d;
            for (int c = 0; c < NCH; c++) begin
                st[c]  = ($urandom_range(0, 5) == 0);
                sp[c]  = ($urandom_range(0, 40) == 0);
                per[c] = $urandom_range(0, 1) == 1;
                d[c*CW +: CW] = CW'($urandom_range(0, 12));
            end
            drive(st, sp, per, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
